// File: rtl/uart_tx_sched_if.sv
// Requester/transmitter-side signal bundle for uart_tx_sched.
// The master side is the environment (requesters plus uart_tx); the scheduler is the slave.
interface uart_tx_sched_if;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [3:0]  done;
  logic        busy;
  logic        bpsclk;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        tx_stop;

  modport master (
    output req, req_data, tx_stop,
    input  ack, done, busy, bpsclk, tx_en, tx_data
  );

  modport slave (
    input  req, req_data, tx_stop,
    output ack, done, busy, bpsclk, tx_en, tx_data
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin arbiter sharing one uart_tx between four byte requesters.
// Also generates the free-running baud tick and enforces an idle gap after each frame.
module uart_tx_sched #(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned GAP_BITS = 1
) (
  input logic            clk,
  input logic            rst,
  uart_tx_sched_if.slave bus
);

  localparam int unsigned DIV      = CLK_HZ / BAUD;
  localparam logic [15:0] DIV_LAST = 16'(DIV - 1);
  localparam logic [3:0]  GAP_LAST = 4'(GAP_BITS);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t      state, state_nx;
  logic [15:0] baud_cnt;
  logic        bpsclk_q;
  logic [1:0]  last, last_nx;
  logic [1:0]  cur, cur_nx;
  logic [3:0]  gap_cnt, gap_nx;
  logic        tx_en_q, tx_en_nx;
  logic [7:0]  tx_data_q, tx_data_nx;
  logic [3:0]  ack_q, ack_nx;
  logic [3:0]  done_q, done_nx;
  logic [1:0]  win;
  logic        win_vld;

  // Baud tick: never stalled by the scheduler, so uart_tx sees a steady bit clock.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_cnt <= '0;
      bpsclk_q <= 1'b0;
    end else begin
      bpsclk_q <= (baud_cnt == DIV_LAST);
      baud_cnt <= (baud_cnt == DIV_LAST) ? '0 : baud_cnt + 16'd1;
    end
  end

  // Winner search starts just above the last grant and wraps, giving rotation.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!win_vld && bus.req[last + 2'(i + 1)]) begin
        win     = last + 2'(i + 1);
        win_vld = 1'b1;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx   = state;
    last_nx    = last;
    cur_nx     = cur;
    gap_nx     = gap_cnt;
    tx_en_nx   = tx_en_q;
    tx_data_nx = tx_data_q;
    ack_nx     = '0;
    done_nx    = '0;

    unique case (state)
      IDLE: begin
        if (win_vld) begin
          tx_data_nx   = bus.req_data[{win, 3'b000} +: 8];
          tx_en_nx     = 1'b1;
          ack_nx[win]  = 1'b1;
          last_nx      = win;
          cur_nx       = win;
          state_nx     = SEND;
        end
      end
      SEND: begin
        // Dropping tx_en on the edge after tx_stop keeps uart_tx from resending the byte.
        if (bus.tx_stop) begin
          tx_en_nx     = 1'b0;
          done_nx[cur] = 1'b1;
          gap_nx       = '0;
          state_nx     = (GAP_BITS == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (bpsclk_q) begin
          gap_nx = gap_cnt + 4'd1;
          if (gap_nx == GAP_LAST) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: asynchronous active-low reset clears every register, including mid-frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      last      <= 2'd3;
      cur       <= 2'd0;
      gap_cnt   <= '0;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
      ack_q     <= '0;
      done_q    <= '0;
    end else begin
      state     <= state_nx;
      last      <= last_nx;
      cur       <= cur_nx;
      gap_cnt   <= gap_nx;
      tx_en_q   <= tx_en_nx;
      tx_data_q <= tx_data_nx;
      ack_q     <= ack_nx;
      done_q    <= done_nx;
    end
  end

  assign bus.ack     = ack_q;
  assign bus.done    = done_q;
  assign bus.busy    = (state != IDLE);
  assign bus.bpsclk  = bpsclk_q;
  assign bus.tx_en   = tx_en_q;
  assign bus.tx_data = tx_data_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: a DIV=16/GAP=1 instance with a behavioural uart_tx,
// and a DIV=5/GAP=3 instance whose tx_stop is driven by hand for tick and gap timing.
module tb_uart_tx_sched;

  logic clk = 1'b0;
  logic rst;
  logic rst2;

  always #5 clk = ~clk;

  uart_tx_sched_if bus1 ();
  uart_tx_sched_if bus2 ();

  uart_tx_sched #(.CLK_HZ(16), .BAUD(1), .GAP_BITS(1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  uart_tx_sched #(.CLK_HZ(5), .BAUD(1), .GAP_BITS(3)) u_dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (bus2)
  );

  // Behavioural uart_tx: 12 bpsclk pulses per frame (start, 8 data LSB first, 2 stop, end).
  int          m_cnt;
  int          m_starts = 0;
  logic [10:0] m_bits;
  logic [10:0] frame_q[$];

  always @(posedge clk or negedge rst) begin
    logic bit_v;
    if (!rst) begin
      m_cnt        <= 0;
      m_bits       <= '0;
      bus1.tx_stop <= 1'b0;
    end else begin
      bus1.tx_stop <= 1'b0;
      if (bus1.tx_en && bus1.bpsclk) begin
        if (m_cnt == 0)      bit_v = 1'b0;
        else if (m_cnt <= 8) bit_v = bus1.tx_data[m_cnt - 1];
        else                 bit_v = 1'b1;
        if (m_cnt == 0) m_starts <= m_starts + 1;
        if (m_cnt <= 10) m_bits[m_cnt] <= bit_v;
        if (m_cnt == 11) begin
          bus1.tx_stop <= 1'b1;
          frame_q.push_back(m_bits);
        end
        m_cnt <= (m_cnt == 11) ? 0 : m_cnt + 1;
      end
    end
  end

  int   stop_err    = 0;
  int   overlap_err = 0;
  logic stop_seen   = 1'b0;

  always @(negedge clk) begin
    if (stop_seen && bus1.tx_en) stop_err++;
    stop_seen = bus1.tx_stop;
    if (((bus1.ack & bus1.done) != 0) || ((bus2.ack & bus2.done) != 0)) overlap_err++;
  end

  int n_pass   = 0;
  int n_fail   = 0;
  int n_checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [3:0] rearm;
  int         ack_log[$];
  int         done_log[$];

  // One clock of requester behaviour: log pulses, drop acked bits, re-raise rearmed ones.
  task automatic step();
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      if (bus1.ack[k])  ack_log.push_back(k);
      if (bus1.done[k]) done_log.push_back(k);
    end
    bus1.req = (bus1.req | rearm) & ~bus1.ack;
  endtask

  function automatic logic [31:0] pack(input int q[$]);
    logic [31:0] r = '0;
    foreach (q[i]) r = {r[27:0], 4'(q[i] + 1)};
    return r;
  endfunction

  task automatic check_frame(input string tag, input logic [7:0] b);
    logic [10:0] fr;
    fr = (frame_q.size() != 0) ? frame_q.pop_front() : '0;
    check(tag, 64'(fr), 64'({2'b11, b, 1'b0}));
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (bus1.busy && n < budget) begin
      step();
      n++;
    end
    check(tag, 64'(bus1.busy), 0);
  endtask

  task automatic wait_ack(input string tag, input int budget);
    int n = 0;
    do begin
      step();
      n++;
    end while (bus1.ack == 0 && n < budget);
    check(tag, 64'(bus1.ack != 0), 1);
  endtask

  initial begin
    int cyc;
    int pulses;
    rearm         = '0;
    bus1.req      = '0;
    bus1.req_data = '0;
    bus2.req      = '0;
    bus2.req_data = '0;
    bus2.tx_stop  = 1'b0;
    rst  = 1'b1;
    rst2 = 1'b1;
    #2;
    rst  = 1'b0;
    rst2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outputs", 64'({bus1.ack, bus1.done, bus1.busy, bus1.bpsclk, bus1.tx_en, bus1.tx_data}), 0);
    check("rst_outputs2", 64'({bus2.ack, bus2.done, bus2.busy, bus2.bpsclk, bus2.tx_en, bus2.tx_data}), 0);
    rst  = 1'b1;
    rst2 = 1'b1;

    // Single request
    repeat (2) step();
    bus1.req_data = 32'h0000_00A5;
    bus1.req      = 4'b0001;
    step();
    check("t1_ack", 64'(bus1.ack), 4'b0001);
    check("t1_busy_tx_en", 64'({bus1.busy, bus1.tx_en}), 2'b11);
    check("t1_tx_data", 64'(bus1.tx_data), 8'hA5);
    step();
    check("t1_ack_low", 64'(bus1.ack), 0);
    cyc = 0;
    while (bus1.done == 0 && cyc < 300) begin
      step();
      cyc++;
    end
    check("t1_done", 64'(bus1.done), 4'b0001);
    check("t1_done_latency", 64'((cyc + 1) >= 178 && (cyc + 1) <= 194), 1);
    check("t1_tx_en_low", 64'(bus1.tx_en), 0);
    check("t1_busy_in_gap", 64'(bus1.busy), 1);
    wait_idle("t1_idle", 100);
    repeat (40) step();
    check("t1_single_frame", 64'(m_starts), 1);
    check_frame("t1_frame_bits", 8'hA5);

    // Simultaneous requests from reset: rotation 0,1,2,3
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    ack_log.delete();
    done_log.delete();
    frame_q.delete();
    bus1.req_data = 32'h4332_2110;
    bus1.req      = 4'hF;
    for (int i = 0; i < 1200 && done_log.size() < 4; i++) step();
    wait_idle("t2_idle", 100);
    check("t2_ack_order", 64'(pack(ack_log)), 32'h1234);
    check("t2_done_order", 64'(pack(done_log)), 32'h1234);
    check("t2_req_dropped", 64'(bus1.req), 0);
    check_frame("t2_frame0", 8'h10);
    check_frame("t2_frame1", 8'h21);
    check_frame("t2_frame2", 8'h32);
    check_frame("t2_frame3", 8'h43);

    // Fairness: 0 and 2 keep requesting, 1 joins during the third frame
    ack_log.delete();
    frame_q.delete();
    rearm    = 4'b0101;
    bus1.req = 4'b0101;
    for (int i = 0; i < 1000 && ack_log.size() < 3; i++) step();
    bus1.req = bus1.req | 4'b0010;
    for (int i = 0; i < 1000 && ack_log.size() < 6; i++) step();
    rearm    = '0;
    bus1.req = '0;
    wait_idle("t3_idle", 400);
    check("t3_grant_order", 64'(pack(ack_log)), 32'h0013_1231);
    check("t3_frame_count", 64'(frame_q.size()), 6);

    // Withdrawn request is never served
    ack_log.delete();
    done_log.delete();
    frame_q.delete();
    bus1.req = 4'b0001;
    wait_ack("t4_ack_seen", 20);
    repeat (20) step();
    bus1.req = bus1.req | 4'b1000;
    repeat (3) step();
    bus1.req = bus1.req & 4'b0111;
    wait_idle("t4_idle", 400);
    repeat (10) step();
    check("t4_acks", 64'(pack(ack_log)), 32'h1);
    check("t4_dones", 64'(pack(done_log)), 32'h1);
    check_frame("t4_frame", 8'h10);

    // Reset in the middle of a frame
    ack_log.delete();
    done_log.delete();
    frame_q.delete();
    bus1.req_data = 32'h0000_E75C;
    bus1.req      = 4'b0001;
    wait_ack("t5_first_ack", 20);
    cyc = 0;
    while (m_cnt != 5 && cyc < 200) begin
      step();
      cyc++;
    end
    check("t5_bit4_reached", 64'(m_cnt == 5), 1);
    bus1.req = 4'b0011;
    rst = 1'b0;
    #1;
    check("t5_async_clear", 64'({bus1.ack, bus1.done, bus1.busy, bus1.bpsclk, bus1.tx_en, bus1.tx_data}), 0);
    repeat (3) step();
    check("t5_held_clear", 64'({bus1.ack, bus1.done, bus1.busy, bus1.bpsclk, bus1.tx_en, bus1.tx_data}), 0);
    rst = 1'b1;
    ack_log.delete();
    step();
    check("t5_req0_wins", 64'(bus1.ack), 4'b0001);
    for (int i = 0; i < 1000 && done_log.size() < 2; i++) step();
    wait_idle("t5_idle", 100);
    check("t5_grants", 64'(pack(ack_log)), 32'h12);
    check_frame("t5_frame0", 8'h5C);
    check_frame("t5_frame1", 8'hE7);
    rst      = 1'b0;
    bus1.req = 4'b0010;
    repeat (2) step();
    rst = 1'b1;
    step();
    check("t5_req1_alone", 64'(bus1.ack), 4'b0010);
    wait_idle("t5_idle2", 400);

    // Baud tick period and gap length on the DIV=5, GAP_BITS=3 instance
    rst2 = 1'b0;
    repeat (2) step();
    rst2 = 1'b1;
    cyc  = 0;
    do begin step(); cyc++; end while (!bus2.bpsclk && cyc < 20);
    check("t6_first_tick", 64'(cyc), 5);
    for (int p = 0; p < 2; p++) begin
      cyc = 0;
      do begin step(); cyc++; end while (!bus2.bpsclk && cyc < 20);
      check($sformatf("t6_period%0d", p), 64'(cyc), 5);
    end
    repeat (2) step();
    rst2 = 1'b0;
    step();
    rst2 = 1'b1;
    cyc  = 0;
    do begin step(); cyc++; end while (!bus2.bpsclk && cyc < 20);
    check("t6_tick_after_rst", 64'(cyc), 5);

    bus2.req_data = 32'h0000_C33C;
    bus2.req      = 4'b0001;
    step();
    check("t6_ack", 64'(bus2.ack), 4'b0001);
    check("t6_tx_data", 64'(bus2.tx_data), 8'h3C);
    bus2.req = '0;
    repeat (7) step();
    bus2.tx_stop = 1'b1;
    step();
    bus2.tx_stop = 1'b0;
    check("t6_done", 64'({bus2.done, bus2.tx_en, bus2.busy}), 6'b0001_0_1);
    pulses   = int'(bus2.bpsclk);
    bus2.req = 4'b0010;
    cyc      = 0;
    while (cyc < 40) begin
      step();
      cyc++;
      if (bus2.ack != 0) break;
      pulses += int'(bus2.bpsclk);
    end
    check("t6_next_ack", 64'(bus2.ack), 4'b0010);
    check("t6_gap_pulses", 64'(pulses), 3);

    check("tx_en_low_after_stop", 64'(stop_err), 0);
    check("ack_done_overlap", 64'(overlap_err), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares the single `uart_tx` serial transmitter between four byte-producing requesters, such as the note/status reporter and debug taps. It generates the baud tick `bpsclk` and picks one pending requester. It latches that requester's byte, holds `tx_en`/`tx_data` stable for the whole frame, and releases the transmitter on `tx_stop`. It sits between the requesters and `uart_tx` and is the only driver of `uart_tx`'s `tx_en`, `tx_data` and `bpsclk` inputs.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency.
- `BAUD`, default 9600: serial bit rate. `DIV = CLK_HZ/BAUD` (integer division) must be ≥ 2 and ≤ 65535.
- `GAP_BITS`, default 1: idle bit periods (bpsclk pulses) enforced after each frame, range 0..15.
- `clk`  in  1: system clock, all logic on the rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `req`  in  4: per-requester level request. Bit k is held high until `ack[k]`.
- `req_data`  in  32: byte k is bits [8k+7:8k]. It is only sampled in the grant cycle.
- `ack`  out  4: one-cycle pulse, byte k latched.
- `done`  out  4: one-cycle pulse, byte k fully sent.
- `busy`  out  1: high in every state except IDLE.
- `bpsclk`  out  1: one-cycle baud tick to `uart_tx`.
- `tx_en`  out  1: enable to `uart_tx`.
- `tx_data`  out  8: byte to `uart_tx`. It is stable while `tx_en` is high.
- `tx_stop`  in  1: one-cycle end-of-frame pulse from `uart_tx`.

## Operation
- **Baud tick**
  - Free-running 16-bit counter, 0..DIV-1.
  - `bpsclk` is a registered pulse, high for the one cycle after the counter reaches DIV-1.
  - The tick runs independently of scheduler state and is never stalled.
- **State machine:** IDLE, SEND, GAP.
- **IDLE**
  - If `req != 0`, pick the winner w: the first set bit searching upward from (last+1) mod 4, wrapping.
  - Register:
    - `tx_data <= req_data[8w+7:8w]`
    - `tx_en <= 1`
    - `ack[w] <= 1` for one cycle
    - `last <= w`
    - `cur <= w`
    - state → SEND.
  - If `req == 0`, stay in IDLE.
- **SEND**
  - `tx_en` stays high and `tx_data` is held. `req` is ignored.
  - On `tx_stop == 1`:
    - `tx_en <= 0`
    - `done[cur] <= 1` for one cycle
    - gap counter ← 0
    - state → GAP, or → IDLE if `GAP_BITS == 0`.
  - `tx_en` must fall on the edge right after the `tx_stop` cycle. This prevents `uart_tx` from restarting a second frame of the same byte.
- **GAP**
  - The gap counter increments on each `bpsclk`.
  - When it reaches `GAP_BITS`, state → IDLE.
  - `req` is ignored.
- **Requester rules**
  - A requester may deassert `req` before its ack; it is then simply not served.
  - A requester may reassert `req` the cycle after ack. It is served after at most three other frames.
- **Round-robin**
  - The `last` pointer updates only on grant.
  - Simultaneous requests are served in rotation, never by fixed priority except from reset.
- **Reset (asynchronous, any state, including mid-frame)**
  - state = IDLE, `last` = 3 (so req0 wins first), `cur` = 0.
  - Baud counter = 0 and gap counter = 0.
  - All outputs are 0: `ack`, `done`, `busy`, `bpsclk`, `tx_en`, `tx_data`.
  - `uart_tx` shares `rst`, so both blocks restart together.

## Timing
- **Grant latency**
  - `req` high in IDLE at cycle N gives `ack`, `tx_en` and `busy` high at cycle N+1.
  - `ack` is low again at N+2.
- **Frame length**
  - `uart_tx` needs 12 `bpsclk` pulses from `tx_en` rising to `tx_stop`.
  - Frame time is therefore between 11·DIV+1 and 12·DIV+1 cycles after `tx_en` rises, depending on baud phase.
- **Frame end**
  - `tx_stop` at cycle M gives `done[cur]` high and `tx_en` low at M+1.
  - `busy` stays high through GAP.
  - With `GAP_BITS == 0`, the earliest next `ack` is at M+2.
- **Busy:** `busy` is combinational from state (state ≠ IDLE), so it rises at N+1 together with `ack`.
- **No overlap:** `ack` and `done` are never high for the same requester in the same cycle.

## Test plan
1. **Single request:** CLK_HZ=16, BAUD=1, GAP_BITS=1, req=4'b0001, byte0=8'hA5.
   - `ack[0]` one cycle after `req`.
   - `tx_out` shows start bit 0, then 1,0,1,0,0,1,0,1 (LSB first), then stop bits 1,1.
   - `done[0]` ≤ 12·16+2 cycles after `ack`.
   - `tx_en` low the cycle after `tx_stop`.
   - No second frame follows.
2. **Simultaneous requests:** req=4'hF held, bytes 8'h10, 8'h21, 8'h32, 8'h43.
   - Acks in order 0,1,2,3.
   - Four frames with those bytes.
   - Each `req` is dropped on its ack.
3. **Fairness:** req0 and req2 continuously reasserted after each ack.
   - Grants alternate 0,2,0,2.
   - req1 raised mid-stream is granted immediately after the currently sending requester.
4. **Withdraw:** req3 pulsed high then low during another frame's SEND.
   - `ack[3]` never fires and `done[3]` never fires.
5. **Reset mid-frame:** assert `rst` low for 3 cycles at bit 4 of a frame.
   - All outputs are 0 immediately.
   - After release, a pending req1 is granted before req0 only if req0 is low; with both pending, req0 wins.
   - The frame is sent cleanly.
6. **Baud/gap:** DIV=5 and GAP_BITS=3.
   - `bpsclk` period is exactly 5 cycles, including across reset.
   - Exactly 3 `bpsclk` pulses fall between `done` and the next `ack`.
